// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Stall controller for the five-stage pipeline. It handles the hazards that
// EX-stage forwarding cannot cover:
//   - a load-use dependency gets a one-cycle bubble in ID/EX while PC and
//     IF/ID hold;
//   - a data-memory/cache wait freezes the whole pipeline.
// It also keeps saturating stall statistics and a sticky memory-timeout flag.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   ID_valid_i         ID holds a real instruction
//   ID_rs1_i/rs2_i     ID source registers
//   ID_use_rs2_i       ID instruction really reads rs2
//   EX_MemRead_i       EX instruction is a load
//   EX_Rd_i            EX destination register
//   mem_stall_i        data memory not ready this cycle
//   PCWrite_o          PC update enable
//   IFID_Write_o       IF/ID write enable
//   IDEX_Bubble_o      load a NOP into ID/EX
//   Freeze_o           hold every pipeline register
//   stall_cnt_o        cycles with any stall (saturating)
//   lu_cnt_o           load-use bubbles inserted (saturating)
//   timeout_o          sticky: memory wait reached MEM_TIMEOUT cycles
module hazard_stall_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_valid_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_use_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             mem_stall_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IDEX_Bubble_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic             timeout_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    LU  = 2'd1,
    MEM = 2'd2
  } state_t;

  state_t             state_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [CNT_W-1:0]   lu_cnt_reg;
  logic               timeout_reg;

  logic lu_raw;
  logic lu_hit;
  logic bubble_event;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu_raw = ID_valid_i && EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                  ((EX_Rd_i == ID_rs1_i) || (ID_use_rs2_i && (EX_Rd_i == ID_rs2_i)));

  // The cycle after a bubble the same ID instruction is still visible; the
  // LU state masks it so one load costs at most one bubble.
  assign lu_hit = lu_raw && (state_reg != LU);

  // Freeze wins over a bubble: the held load is re-evaluated once memory
  // wait ends.
  assign bubble_event = !mem_stall_i && lu_hit;

  always_comb begin
    PCWrite_o     = !mem_stall_i && !lu_hit;
    IFID_Write_o  = !mem_stall_i && !lu_hit;
    IDEX_Bubble_o = bubble_event;
    Freeze_o      = mem_stall_i;
    if (rst_i) begin
      // Keep the front end parked and ID/EX flushed while in reset.
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Bubble_o = 1'b1;
      Freeze_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      lu_cnt_reg    <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (mem_stall_i)      state_reg <= MEM;
          else if (lu_hit)      state_reg <= LU;
          else                  state_reg <= RUN;
        end
        LU: begin
          if (mem_stall_i)      state_reg <= MEM;
          else                  state_reg <= RUN;
        end
        MEM: begin
          if (mem_stall_i)      state_reg <= MEM;
          else if (lu_raw)      state_reg <= LU;
          else                  state_reg <= RUN;
        end
        default:                state_reg <= RUN;
      endcase

      // Consecutive-wait counter; the edge that closes the MEM_TIMEOUT-th
      // stall cycle sets the sticky flag. Holding at all-ones avoids a wrap
      // back through the threshold on very long waits.
      if (mem_stall_i) begin
        if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) timeout_reg <= 1'b1;
        if (wait_cnt_reg != '1) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end

      if ((mem_stall_i || lu_hit) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;

      if (bubble_event && (lu_cnt_reg != '1))
        lu_cnt_reg <= lu_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign lu_cnt_o    = lu_cnt_reg;
  assign timeout_o   = timeout_reg;

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline stall controller for the five-stage RISC-V core. It complements the EX-stage forwarding logic by handling the hazards forwarding cannot cover:
- load-use dependencies, resolved with a one-cycle bubble;
- data-memory/cache wait cycles, resolved by freezing the whole pipeline.

It drives the PC, IF/ID, ID/EX and whole-pipeline write enables. It also keeps saturating stall statistics and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 16: width of the statistics counters.
- MEM_TIMEOUT, 1024: consecutive memory-wait cycles that set timeout_o (≥ 2).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ID_valid_i  in  1  ID stage holds a real instruction (not a bubble).
- ID_rs1_i  in  5  ID-stage source register 1.
- ID_rs2_i  in  5  ID-stage source register 2.
- ID_use_rs2_i  in  1  ID instruction actually reads rs2 (R/S/B types).
- EX_MemRead_i  in  1  EX-stage instruction is a load.
- EX_Rd_i  in  5  EX-stage destination register.
- mem_stall_i  in  1  data memory/cache not ready this cycle.
- PCWrite_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID register write enable.
- IDEX_Bubble_o  out  1  load NOP control into ID/EX instead of ID outputs.
- Freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB (and PC, IF/ID).
- stall_cnt_o  out  CNT_W  cycles with any stall.
- lu_cnt_o  out  CNT_W  load-use bubbles inserted.
- timeout_o  out  1  sticky: memory wait reached MEM_TIMEOUT.

## Operation
- Load-use hazard (raw):
  - lu_raw = ID_valid_i & EX_MemRead_i & (EX_Rd_i != 0) & ((EX_Rd_i == ID_rs1_i) | (ID_use_rs2_i & EX_Rd_i == ID_rs2_i)).
  - A destination of x0 never causes a hazard.
- lu_hit = lu_raw & (state != LU). The guard allows at most one bubble per load.
- States: RUN, LU, MEM. All transitions are evaluated at the clock edge.
  - RUN → MEM if mem_stall_i.
  - RUN → LU if !mem_stall_i & lu_hit.
  - Otherwise RUN → RUN.
  - LU → MEM if mem_stall_i, else LU → RUN. LU lasts exactly one cycle.
  - MEM → MEM while mem_stall_i.
  - MEM → LU if !mem_stall_i & lu_raw. The frozen load was never bubbled, so this re-evaluates the hazard.
  - MEM → RUN otherwise.
- Outputs are combinational from inputs and state:
  - Freeze_o = mem_stall_i.
  - PCWrite_o = IFID_Write_o = !mem_stall_i & !lu_hit.
  - IDEX_Bubble_o = !mem_stall_i & lu_hit.
  - Freeze has priority: no bubble is inserted while frozen.
- Memory-wait counter (internal, ≥ clog2(MEM_TIMEOUT)+1 bits):
  - increments each cycle mem_stall_i is high;
  - clears when mem_stall_i is low;
  - timeout_o is set on the edge where the count reaches MEM_TIMEOUT-1 with mem_stall_i still high, i.e. after MEM_TIMEOUT consecutive stall cycles;
  - timeout_o is cleared only by rst_i.
- Statistics counters, both saturating at all-ones (no wrap):
  - stall_cnt_o += 1 on each edge where mem_stall_i | lu_hit;
  - lu_cnt_o += 1 on each edge where IDEX_Bubble_o.

## Timing
- Reset (rst_i high at an edge): state = RUN, counters = 0, wait counter = 0, timeout_o = 0.
- While rst_i is high, the combinational outputs are forced: PCWrite_o = 0, IFID_Write_o = 0, IDEX_Bubble_o = 1, Freeze_o = 0.
- Reset mid-stall abandons the stall. After reset deasserts, the unit is in RUN and evaluates inputs fresh.
- Zero-latency control: hazard/stall outputs respond in the same cycle as the inputs.
- Registered outputs (counters, timeout_o) reflect an event one edge after it.
- Load-use cost:
  - exactly 1 stall cycle;
  - in the next cycle the load has moved to MEM and EX holds a bubble, so lu_raw is normally 0 there;
  - the LU state masks it regardless.
- Memory-stall cost: exactly the number of mem_stall_i-high cycles. PC, IF/ID and all downstream registers hold.
- Simultaneous load-use and mem_stall_i: freeze only, no bubble, no lu_cnt increment; stall_cnt increments once.

## Test plan
- Load-use: ID_valid=1, EX_MemRead=1, EX_Rd=5, ID_rs1=5 for 2 cycles.
  - Cycle 1: PCWrite=0, IFID_Write=0, IDEX_Bubble=1.
  - Cycle 2 (state LU): PCWrite=1, IDEX_Bubble=0.
  - lu_cnt=1, stall_cnt=1.
- x0 and rs2 gating:
  - EX_Rd=0 = ID_rs1 → no stall.
  - EX_Rd=7 = ID_rs2 with ID_use_rs2=0 → no stall; with ID_use_rs2=1 → bubble.
- Memory stall: mem_stall_i high 3 cycles.
  - Freeze=1, PCWrite=0, IDEX_Bubble=0 throughout.
  - stall_cnt=3, state returns to RUN.
- Simultaneous events: load-use hazard held while mem_stall_i high 2 cycles, then low.
  - No bubble during the freeze.
  - One bubble in the first unfrozen cycle.
  - lu_cnt=1, stall_cnt=3.
- Timeout and saturation: MEM_TIMEOUT=4 with mem_stall_i high 4 cycles → timeout_o=1 after the 4th edge; it stays 1 after the stall ends until rst_i.
- Counter saturation: CNT_W=2 with 5 stalls → stall_cnt=3.
- Reset mid-stall: rst_i pulsed during a stall → counters 0, timeout_o 0, state RUN.
